// File: rtl/sprite_hit_engine.sv
// Grid-based sprite collision engine: clears four class occupancy maps, draws every
// sprite into its class map, then flags sprites whose cell holds an opposing class.
module sprite_hit_engine #(
  parameter int SPRITE_NUM       = 64,
  parameter int GRID_W           = 32,
  parameter int GRID_H           = 32,
  parameter int CELL_SHIFT       = 3,
  parameter int HP_LO            = 10,
  parameter int HP_HI            = 13,
  parameter int HB_TILE          = 14,
  parameter int EP_LO            = 15,
  parameter int EP_HI            = 17,
  parameter int EB_TILE          = 18,
  parameter int BULLET_VS_BULLET = 0,
  localparam int AW = $clog2(SPRITE_NUM),
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  output logic [AW-1:0]         spr_addr,
  input  logic [31:0]           spr_data,
  output logic [SPRITE_NUM-1:0] hit_vec,
  output logic [AW:0]           hit_count,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            fsm_state
);

  // Control protocol: start is a level request sampled only in IDLE (no queueing);
  // done is a single-cycle pulse coinciding with the hit_vec/hit_count update;
  // abort wins over everything except reset and leaves the results untouched.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_DRAW  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [AW:0]           idx;
  logic [YW-1:0]         row;
  logic [SPRITE_NUM-1:0] shadow;
  logic [AW:0]           count;

  logic [GRID_W-1:0] map_hp [GRID_H];
  logic [GRID_W-1:0] map_hb [GRID_H];
  logic [GRID_W-1:0] map_ep [GRID_H];
  logic [GRID_W-1:0] map_eb [GRID_H];

  logic [31:0]           cx_full;
  logic [31:0]           cy_full;
  logic [31:0]           tile_w;
  logic [XW-1:0]         cx;
  logic [YW-1:0]         cy;
  logic                  rec_valid;
  logic                  on_grid;
  logic                  cls_hp;
  logic                  cls_hb;
  logic                  cls_ep;
  logic                  cls_eb;
  logic                  classed;
  logic                  proc;
  logic                  rec_act;
  logic                  last;
  logic [AW-1:0]         proc_addr;
  logic                  c_hp;
  logic                  c_hb;
  logic                  c_ep;
  logic                  c_eb;
  logic                  bvb;
  logic                  hit_bit;
  logic [SPRITE_NUM-1:0] shadow_nxt;
  logic [AW:0]           count_nxt;
  logic                  unused_bits;

  assign unused_bits = ^spr_data[6:0];
  assign bvb         = (BULLET_VS_BULLET != 0);

  // Record decode; cell coordinates stay full width so off-grid sprites cannot alias.
  always_comb begin
    cx_full   = 32'(spr_data[31:24]) >> CELL_SHIFT;
    cy_full   = 32'(spr_data[23:16]) >> CELL_SHIFT;
    tile_w    = 32'(spr_data[15:8]);
    rec_valid = spr_data[7];
    on_grid   = (cx_full < GRID_W) && (cy_full < GRID_H);
    cx        = cx_full[XW-1:0];
    cy        = cy_full[YW-1:0];
    cls_hp    = (tile_w >= HP_LO) && (tile_w <= HP_HI);
    cls_hb    = !cls_hp && (tile_w == HB_TILE);
    cls_ep    = !cls_hp && !cls_hb && (tile_w >= EP_LO) && (tile_w <= EP_HI);
    cls_eb    = !cls_hp && !cls_hb && !cls_ep && (tile_w == EB_TILE);
    classed   = cls_hp || cls_hb || cls_ep || cls_eb;
  end

  // idx = 0 carries no record; idx = k carries the record for address k-1.
  assign proc      = (idx != '0);
  assign last      = (idx == (AW+1)'(SPRITE_NUM));
  assign proc_addr = idx[AW-1:0] - AW'(1);
  assign rec_act   = proc && rec_valid && on_grid && classed;

  always_comb begin
    c_hp = map_hp[cy][cx];
    c_hb = map_hb[cy][cx];
    c_ep = map_ep[cy][cx];
    c_eb = map_eb[cy][cx];
    hit_bit = rec_act && (
                (cls_hp && (c_ep || c_eb)) ||
                (cls_hb && (c_ep || (bvb && c_eb))) ||
                (cls_ep && (c_hp || c_hb)) ||
                (cls_eb && (c_hp || (bvb && c_hb))));
  end

  always_comb begin
    shadow_nxt = shadow;
    count_nxt  = count;
    if (proc) begin
      shadow_nxt[proc_addr] = hit_bit;
      count_nxt             = count + {{AW{1'b0}}, hit_bit};
    end
  end

  always_comb begin
    spr_addr = '0;
    if (state == S_DRAW || state == S_CHECK) begin
      if (idx < (AW+1)'(SPRITE_NUM)) spr_addr = idx[AW-1:0];
      else                           spr_addr = AW'(SPRITE_NUM - 1);
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      idx       <= '0;
      row       <= '0;
      shadow    <= '0;
      count     <= '0;
      hit_vec   <= '0;
      hit_count <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      idx   <= '0;
      row   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLEAR;
            row   <= '0;
          end
        end
        S_CLEAR: begin
          if (row == YW'(GRID_H - 1)) begin
            state <= S_DRAW;
            idx   <= '0;
          end else begin
            row <= row + YW'(1);
          end
        end
        S_DRAW: begin
          if (last) begin
            state  <= S_CHECK;
            idx    <= '0;
            shadow <= '0;
            count  <= '0;
          end else begin
            idx <= idx + (AW+1)'(1);
          end
        end
        S_CHECK: begin
          shadow <= shadow_nxt;
          count  <= count_nxt;
          if (last) begin
            state     <= S_DONE;
            hit_vec   <= shadow_nxt;
            hit_count <= count_nxt;
          end else begin
            idx <= idx + (AW+1)'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Maps need no reset: CLEAR always runs before DRAW touches them.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      map_hp[row] <= '0;
      map_hb[row] <= '0;
      map_ep[row] <= '0;
      map_eb[row] <= '0;
    end else if (state == S_DRAW && rec_act) begin
      if (cls_hp) map_hp[cy][cx] <= 1'b1;
      if (cls_hb) map_hb[cy][cx] <= 1'b1;
      if (cls_ep) map_ep[cy][cx] <= 1'b1;
      if (cls_eb) map_eb[cy][cx] <= 1'b1;
    end
  end

endmodule
